branch_predict_unit: RTL and testbench

- Parametrised successor to the single-cycle branch/jump PC selector.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for fetch-stage prediction.
- Resolves branches/jumps in execute, detects mispredictions and issues a registered redirect to the PC register.
- Sits between the fetch PC register and the execute stage. Execute supplies the ALU compare bit and the immediate.

---
 rtl/branch_predict_unit.sv | 143 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Fetch-stage BTB predictor (direct-mapped, 2-bit counters) with execute-stage resolve and registered redirect.
// Optional build macro BPU_STATS_EN adds branch / mispredict event counters.
module branch_predict_unit #(
  parameter int         PC_WIDTH   = 9,
  parameter int         INDEX_BITS = 4,
  parameter logic [1:0] CTR_INIT   = 2'b01
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_valid,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  input  logic                res_valid,
  input  logic [PC_WIDTH-1:0] res_pc,
  input  logic                res_is_branch,
  input  logic                res_is_jump,
  input  logic                res_cond,
  input  logic [31:0]         res_imm,
  input  logic                res_pred_taken,
  input  logic [31:0]         res_pred_target,
  output logic [31:0]         res_pc_four,
  output logic                mispredict,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;

  logic                r_valid  [ENTRIES];
  logic [TAG_W-1:0]    r_tag    [ENTRIES];
  logic [PC_WIDTH-1:0] r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];

  logic [INDEX_BITS-1:0] w_fetch_idx;
  logic [TAG_W-1:0]      w_fetch_tag;
  logic                  w_fetch_hit;
  logic                  w_fetch_taken;
  logic [31:0]           w_fetch_pc32;
  logic [INDEX_BITS-1:0] w_res_idx;
  logic [TAG_W-1:0]      w_res_tag;
  logic                  w_res_hit;
  logic                  w_res_ctrl;
  logic [31:0]           w_res_pc32;
  logic                  w_actual_taken;
  logic [31:0]           w_actual_target;
  logic [1:0]            w_new_ctr;
  logic                  w_unused_bits;

  assign w_fetch_idx   = fetch_pc[INDEX_BITS+1:2];
  assign w_fetch_tag   = fetch_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign w_fetch_hit   = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
  assign w_fetch_taken = w_fetch_hit && r_ctr[w_fetch_idx][1];
  assign w_fetch_pc32  = {{(32-PC_WIDTH){1'b0}}, fetch_pc};

  assign w_res_idx  = res_pc[INDEX_BITS+1:2];
  assign w_res_tag  = res_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign w_res_hit  = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);
  assign w_res_ctrl = res_is_branch | res_is_jump;
  assign w_res_pc32 = {{(32-PC_WIDTH){1'b0}}, res_pc};

  assign res_pc_four     = w_res_pc32 + 32'd4;
  assign w_actual_taken  = res_is_jump | (res_is_branch & res_cond);
  assign w_actual_target = w_actual_taken ? (w_res_pc32 + res_imm) : res_pc_four;
  assign mispredict      = res_valid & ((res_pred_taken != w_actual_taken) |
                           (w_actual_taken & (res_pred_target != w_actual_target)));

  assign w_unused_bits = ^{fetch_pc[1:0], res_pc[1:0]};

  // Jumps always pin the counter to strongly-taken; a fresh branch starts weak in its direction.
  always_comb begin
    w_new_ctr = r_ctr[w_res_idx];
    if (res_is_jump) begin
      w_new_ctr = 2'b11;
    end else if (!w_res_hit) begin
      w_new_ctr = w_actual_taken ? 2'b10 : 2'b01;
    end else if (w_actual_taken) begin
      if (r_ctr[w_res_idx] != 2'b11) w_new_ctr = r_ctr[w_res_idx] + 2'd1;
    end else begin
      if (r_ctr[w_res_idx] != 2'b00) w_new_ctr = r_ctr[w_res_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_INIT;
      end
    end else if (res_valid) begin
      if (w_res_ctrl) begin
        r_valid[w_res_idx]  <= 1'b1;
        r_tag[w_res_idx]    <= w_res_tag;
        r_target[w_res_idx] <= w_actual_target[PC_WIDTH-1:0];
        r_ctr[w_res_idx]    <= w_new_ctr;
      end else if (w_res_hit) begin
        r_valid[w_res_idx] <= 1'b0;
      end
    end
  end

  // Lookup samples the array before this edge's update lands (read-before-write).
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid     <= 1'b0;
      pred_taken     <= 1'b0;
      pred_target    <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      pred_valid     <= fetch_valid;
      redirect_valid <= mispredict;
      if (fetch_valid) begin
        pred_taken  <= w_fetch_taken;
        pred_target <= w_fetch_taken ? {{(32-PC_WIDTH){1'b0}}, r_target[w_fetch_idx]}
                                     : (w_fetch_pc32 + 32'd4);
      end
      if (mispredict) redirect_pc <= w_actual_target;
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (res_valid && w_res_ctrl) stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed scoreboard bench for branch_predict_unit: stimulus pushes expected predictions/redirects,
// a negedge monitor pops and compares whenever pred_valid or redirect_valid is presented.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [8:0]  fetch_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [8:0]  res_pc;
  logic        res_is_branch;
  logic        res_is_jump;
  logic        res_cond;
  logic [31:0] res_imm;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic [31:0] res_pc_four;
  logic        mispredict;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [32:0] predQ[$];
  logic [31:0] redirQ[$];

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .pred_valid      (pred_valid),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_is_branch   (res_is_branch),
    .res_is_jump     (res_is_jump),
    .res_cond        (res_cond),
    .res_imm         (res_imm),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .res_pc_four     (res_pc_four),
    .mispredict      (mispredict),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock of stimulus; expectations for the registered outputs go to the scoreboard queues.
  task automatic applyStimulus(
    input bit rst, input bit fv, input logic [8:0] fpc,
    input bit expTaken, input logic [31:0] expTgt,
    input bit rv, input logic [8:0] rpc, input bit isb, input bit isj, input bit cond,
    input logic [31:0] imm, input bit pt, input logic [31:0] ptgt,
    input bit expMisp, input logic [31:0] expRedir);
    @(posedge clk);
    #1;
    reset           = rst;
    fetch_valid     = fv;
    fetch_pc        = fpc;
    res_valid       = rv;
    res_pc          = rpc;
    res_is_branch   = isb;
    res_is_jump     = isj;
    res_cond        = cond;
    res_imm         = imm;
    res_pred_taken  = pt;
    res_pred_target = ptgt;
    if (fv && !rst) predQ.push_back({expTaken, expTgt});
    #1;
    checkOutput("mispredict", {31'b0, mispredict}, {31'b0, expMisp});
    if (rv) checkOutput("res_pc_four", res_pc_four, {23'b0, rpc} + 32'd4);
    if (expMisp && !rst) redirQ.push_back(expRedir);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 9'h0, 0, 32'h0, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (pred_valid === 1'b1) begin
      if (predQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL pred_valid: got unexpected prediction 0x%08h, expected none", pred_target);
      end else begin
        logic [32:0] e;
        e = predQ.pop_front();
        checkOutput("pred_taken", {31'b0, pred_taken}, {31'b0, e[32]});
        checkOutput("pred_target", pred_target, e[31:0]);
      end
    end
    if (redirect_valid === 1'b1) begin
      if (redirQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL redirect_valid: got unexpected redirect 0x%08h, expected none", redirect_pc);
      end else begin
        checkOutput("redirect_pc", redirect_pc, redirQ.pop_front());
      end
    end
  end

  initial begin
    applyStimulus(1, 0, 9'h0, 0, 32'h0, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    applyStimulus(1, 0, 9'h0, 0, 32'h0, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkOutput("reset_pred_valid", {31'b0, pred_valid}, 32'h0);
    checkOutput("reset_pred_taken", {31'b0, pred_taken}, 32'h0);
    checkOutput("reset_pred_target", pred_target, 32'h0);
    checkOutput("reset_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    checkOutput("reset_redirect_pc", redirect_pc, 32'h0);

    // cold lookup, then taken branch allocates ctr=10
    applyStimulus(0, 1, 9'h010, 0, 32'h014, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    applyStimulus(0, 0, 9'h0, 0, 32'h0, 1, 9'h010, 1, 0, 1, 32'h20, 0, 32'h0, 1, 32'h030);
    idle();
    applyStimulus(0, 1, 9'h010, 1, 32'h030, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    // two not-taken resolves: 10 -> 01 -> 00
    applyStimulus(0, 0, 9'h0, 0, 32'h0, 1, 9'h010, 1, 0, 0, 32'h20, 1, 32'h030, 1, 32'h014);
    applyStimulus(0, 0, 9'h0, 0, 32'h0, 1, 9'h010, 1, 0, 0, 32'h20, 0, 32'h014, 0, 32'h0);
    applyStimulus(0, 1, 9'h010, 0, 32'h014, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    // saturation at 00, then two taken resolves climb 00 -> 01 -> 10
    applyStimulus(0, 0, 9'h0, 0, 32'h0, 1, 9'h010, 1, 0, 0, 32'h20, 0, 32'h014, 0, 32'h0);
    applyStimulus(0, 0, 9'h0, 0, 32'h0, 1, 9'h010, 1, 0, 1, 32'h20, 0, 32'h014, 1, 32'h030);
    applyStimulus(0, 1, 9'h010, 0, 32'h014, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    applyStimulus(0, 0, 9'h0, 0, 32'h0, 1, 9'h010, 1, 0, 1, 32'h20, 0, 32'h014, 1, 32'h030);
    applyStimulus(0, 1, 9'h010, 1, 32'h030, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    // backward jump correctly predicted, then branch+jump flags act as jump
    applyStimulus(0, 0, 9'h0, 0, 32'h0, 1, 9'h040, 0, 1, 0, 32'hFFFFFFF8, 1, 32'h038, 0, 32'h0);
    applyStimulus(0, 1, 9'h040, 1, 32'h038, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    applyStimulus(0, 0, 9'h0, 0, 32'h0, 1, 9'h040, 1, 1, 0, 32'h10, 1, 32'h038, 1, 32'h050);
    applyStimulus(0, 1, 9'h040, 1, 32'h050, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    // alias on index 4, then non-branch hit evicts the entry
    applyStimulus(0, 1, 9'h050, 0, 32'h054, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    applyStimulus(0, 0, 9'h0, 0, 32'h0, 1, 9'h010, 0, 0, 0, 32'h0, 1, 32'h030, 1, 32'h014);
    applyStimulus(0, 1, 9'h010, 0, 32'h014, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    // same-cycle lookup/update sees the old entry; the next lookup sees the new one
    applyStimulus(0, 0, 9'h0, 0, 32'h0, 1, 9'h010, 0, 1, 0, 32'h20, 0, 32'h0, 1, 32'h030);
    applyStimulus(0, 1, 9'h010, 1, 32'h030, 1, 9'h010, 1, 0, 0, 32'h20, 1, 32'h030, 1, 32'h014);
    applyStimulus(0, 1, 9'h010, 1, 32'h014, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    // reset during a mispredict drops the redirect and clears the BTB
    applyStimulus(1, 1, 9'h010, 0, 32'h0, 1, 9'h010, 1, 0, 1, 32'h20, 0, 32'h0, 1, 32'h030);
    applyStimulus(0, 1, 9'h010, 0, 32'h014, 0, 9'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkOutput("post_reset_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    checkOutput("post_reset_pred_valid", {31'b0, pred_valid}, 32'h0);
    idle();
    idle();
    idle();
    checkOutput("pending_predictions", predQ.size(), 32'h0);
    checkOutput("pending_redirects", redirQ.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
